// File: rtl/store_buffer.sv
// Store buffer between address generation and the dcache: queues committed stores,
// drains them in order over valid/ready, and offers store-to-load forwarding.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [3:0]               st_strb,
    input  logic [31:0]              st_data,
    input  logic                     ld_check,
    input  logic [31:0]              ld_addr,
    input  logic [3:0]               ld_strb,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic                     fwd_stall,
    output logic                     dc_valid,
    input  logic                     dc_ready,
    output logic [31:0]              dc_addr,
    output logic [3:0]               dc_strb,
    output logic [31:0]              dc_wdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW:0]    head_q, head_d;
    logic [PW:0]    tail_q, tail_d;

    logic [PW-1:0]  head_idx, tail_idx;
    logic           full;
    logic           enq, deq;
    entry_t         head_entry;

    // Byte-offset bits of both addresses are irrelevant: all accesses are word-lane aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    assign count = tail_q - head_q;
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    assign st_ready = ~full;
    assign dc_valid = ~empty;

    assign enq = st_valid & st_ready;
    assign deq = dc_valid & dc_ready;

    // Outputs are forced to zero while empty so stale storage never leaks onto the port.
    assign head_entry = mem_q[head_idx];
    assign dc_addr    = dc_valid ? {head_entry.addr, 2'b00} : 32'h0;
    assign dc_strb    = dc_valid ? head_entry.strb : 4'h0;
    assign dc_wdata   = dc_valid ? head_entry.data : 32'h0;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, or a latch is inferred.
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (deq) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + 1'b1;
        end
        if (enq) begin
            valid_d[tail_idx] = 1'b1;
            tail_d            = tail_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload array is not reset; valid bits and pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_idx] <= '{addr: st_addr[31:2], strb: st_strb, data: st_data};
        end
    end

    logic          match_any;
    logic [PW-1:0] match_sel;
    logic [PW-1:0] scan_idx;
    logic          lanes_missing;
    entry_t        match_entry;

    // Walk from head towards tail so the last match seen is the youngest store.
    always_comb begin
        match_any = 1'b0;
        match_sel = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + PW'(i);
            if (valid_q[scan_idx] && (mem_q[scan_idx].addr == ld_addr[31:2])) begin
                match_any = 1'b1;
                match_sel = scan_idx;
            end
        end
    end

    assign match_entry   = mem_q[match_sel];
    assign lanes_missing = |(ld_strb & ~match_entry.strb);

    assign fwd_hit   = ld_check & match_any;
    assign fwd_stall = ld_check & match_any & lanes_missing;
    assign fwd_data  = (ld_check & match_any & ~lanes_missing) ? match_entry.data : 32'h0;

endmodule
